// File: rtl/seg7_pkg.sv
// Seven-segment constants and the BCD-to-segment decode shared by the display blocks.
// Patterns are active-high, packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-BCD codes (10..15) show a dash so a bad upstream value is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high segment pattern decoder.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 7-segment driver: latches packed BCD digits and scans one digit per
// refresh slot, with leading-zero blanking, an anti-ghosting guard and registered outputs.
module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 1,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          LZ_BLANK    = 1'b1,
  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SW-1:0]           slot_idx
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PCNT_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_DIGITS - 1);
  // XOR masks that flip the internal active-high values to the board polarity.
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [PW-1:0]           pcnt_q;
  logic [SW-1:0]           slot_q;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_act;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic                  in_guard;
  logic                  show;
  logic [6:0]            dec_seg;

  // Display register, prescaler and slot counter; load never disturbs the scan timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      pcnt_q <= '0;
      slot_q <= '0;
    end else begin
      if (load) begin
        disp_q <= digits_in;
      end
      if (pcnt_q == PCNT_MAX) begin
        pcnt_q <= '0;
        slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
      end else begin
        pcnt_q <= pcnt_q + PW'(1);
      end
    end
  end

  // Leading-zero mask, scanned-digit mux and one-hot anode for the current slot.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank     = '0;
    an_act    = '0;
    cur_digit = '0;
    cur_blank = 1'b0;
    // Walk down from the top digit; a digit blanks only if it and all above it are zero.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
      blank[i] = LZ_BLANK && zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SW'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_blank = blank[i];
        an_act[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  assign in_guard = 32'(pcnt_q) < GUARD;
  assign show     = !in_guard && !cur_blank;

  // Registered outputs, one cycle behind the state they are decoded from.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF ^ SEG_POL;
      an_q  <= AN_POL;
    end else begin
      seg_q <= (show ? dec_seg : SEG_OFF) ^ SEG_POL;
      an_q  <= (show ? an_act : '0) ^ AN_POL;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign slot_idx = slot_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Scoreboard bench: the stimulus process pushes the hand-computed output expected after each
// clock edge; a monitor pops one entry per edge and compares. A second instance runs with
// leading-zero blanking disabled on the same inputs.
module tb_bcd_seg7_scanner;

  localparam logic [6:0] OFF  = 7'h7F;
  localparam logic [1:0] AOFF = 2'b11;
  localparam logic [1:0] A0   = 2'b10;
  localparam logic [1:0] A1   = 2'b01;

  typedef struct {
    string      name;
    logic [6:0] seg;
    logic [1:0] an;
    logic [6:0] nseg;
    logic [1:0] nan;
    bit         chk_slot;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] digits_in = 8'h00;
  logic [6:0] seg, seg_n;
  logic [1:0] an, an_n;
  logic       slot_idx, slot_n;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  bcd_seg7_scanner #(
    .NUM_DIGITS (2), .REFRESH_DIV (4), .GUARD (1), .ACTIVE_LOW (1'b1), .LZ_BLANK (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .load (load), .digits_in (digits_in),
    .seg (seg), .an (an), .slot_idx (slot_idx)
  );

  bcd_seg7_scanner #(
    .NUM_DIGITS (2), .REFRESH_DIV (4), .GUARD (1), .ACTIVE_LOW (1'b1), .LZ_BLANK (1'b0)
  ) dut_nlz (
    .clk (clk), .rst (rst), .load (load), .digits_in (digits_in),
    .seg (seg_n), .an (an_n), .slot_idx (slot_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".seg"},    {1'b0, seg},   {1'b0, e.seg});
      chk({e.name, ".an"},     {6'd0, an},    {6'd0, e.an});
      chk({e.name, ".seg_nlz"}, {1'b0, seg_n}, {1'b0, e.nseg});
      chk({e.name, ".an_nlz"},  {6'd0, an_n},  {6'd0, e.nan});
      if (e.chk_slot) begin
        chk({e.name, ".slot_idx"}, {7'd0, slot_idx}, 8'd0);
        chk({e.name, ".slot_nlz"}, {7'd0, slot_n},   8'd0);
      end
    end
  end

  // Drive inputs for the next edge and queue the output expected right after it.
  task automatic step(input string nm, input logic r, input logic l, input logic [7:0] d,
                      input logic [6:0] es, input logic [1:0] ea,
                      input logic [6:0] ns, input logic [1:0] na, input bit cs);
    exp_t e;
    @(negedge clk);
    rst       = r;
    load      = l;
    digits_in = d;
    e.name = nm; e.seg = es; e.an = ea; e.nseg = ns; e.nan = na; e.chk_slot = cs;
    sb.push_back(e);
  endtask

  task automatic guard(input string nm);
    step({nm, ".guard"}, 1'b0, 1'b0, 8'h00, OFF, AOFF, OFF, AOFF, 1'b0);
  endtask

  // One full 8-cycle frame; optionally loads the next value on the wrap cycle of slot 1.
  task automatic frame(input string nm, input logic [6:0] s0, input logic [1:0] a0,
                       input logic [6:0] s1, input logic [1:0] a1,
                       input logic [6:0] ns1, input logic [1:0] na1,
                       input logic ld, input logic [7:0] nd);
    guard({nm, ".s0"});
    for (int i = 0; i < 3; i++) step({nm, ".d0"}, 1'b0, 1'b0, 8'h00, s0, a0, s0, a0, 1'b0);
    guard({nm, ".s1"});
    for (int i = 0; i < 2; i++) step({nm, ".d1"}, 1'b0, 1'b0, 8'h00, s1, a1, ns1, na1, 1'b0);
    step({nm, ".d1"}, 1'b0, ld, nd, s1, a1, ns1, na1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 8'h00, OFF, AOFF, OFF, AOFF, 1'b1);

    frame("zero", 7'h40, A0, OFF, AOFF, 7'h40, A1, 1'b1, 8'h15);
    frame("h15",  7'h12, A0, 7'h79, A1, 7'h79, A1, 1'b1, 8'h07);
    frame("h07",  7'h78, A0, OFF, AOFF, 7'h40, A1, 1'b1, 8'h0C);
    frame("h0C",  7'h3F, A0, OFF, AOFF, 7'h40, A1, 1'b0, 8'h00);

    // Load 8'h42 at pcnt=2 of slot 0: old dash once more, then "2" next cycle.
    guard("mid.s0");
    step("mid.old", 1'b0, 1'b0, 8'h00, 7'h3F, A0, 7'h3F, A0, 1'b0);
    step("mid.ld",  1'b0, 1'b1, 8'h42, 7'h3F, A0, 7'h3F, A0, 1'b0);
    step("mid.new", 1'b0, 1'b0, 8'h00, 7'h24, A0, 7'h24, A0, 1'b0);
    guard("mid.s1");
    for (int i = 0; i < 3; i++) step("mid.d1", 1'b0, 1'b0, 8'h00, 7'h19, A1, 7'h19, A1, 1'b0);

    // Load 8'h99 on the wrap cycle of slot 0: slot 1 guard, then "9".
    guard("wrap.s0");
    step("wrap.d0", 1'b0, 1'b0, 8'h00, 7'h24, A0, 7'h24, A0, 1'b0);
    step("wrap.d0", 1'b0, 1'b0, 8'h00, 7'h24, A0, 7'h24, A0, 1'b0);
    step("wrap.ld", 1'b0, 1'b1, 8'h99, 7'h24, A0, 7'h24, A0, 1'b0);
    guard("wrap.s1");
    for (int i = 0; i < 3; i++) step("wrap.d1", 1'b0, 1'b0, 8'h00, 7'h10, A1, 7'h10, A1, 1'b0);

    // Reset at slot 1 pcnt=2: inactive outputs immediately, then scan restarts with disp=0.
    guard("rmid.s0");
    for (int i = 0; i < 3; i++) step("rmid.d0", 1'b0, 1'b0, 8'h00, 7'h10, A0, 7'h10, A0, 1'b0);
    guard("rmid.s1");
    step("rmid.d1", 1'b0, 1'b0, 8'h00, 7'h10, A1, 7'h10, A1, 1'b0);
    step("rmid.rst", 1'b1, 1'b0, 8'h00, OFF, AOFF, OFF, AOFF, 1'b1);
    frame("post", 7'h40, A0, OFF, AOFF, 7'h40, A1, 1'b0, 8'h00);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
